// File: rtl/commit_unit_pkg.sv
// Shared opcode encoding, ROB tag width and commit FSM state encoding.
// Imported by commit_unit, commit_classify and the ROB/LSB partners.
package commit_unit_pkg;

  localparam int ROB_ID_WIDTH = 4;

  typedef enum logic [4:0] {
    ALU_OP_ADD   = 5'd0,
    ALU_OP_SUB   = 5'd1,
    ALU_OP_AND   = 5'd2,
    ALU_OP_OR    = 5'd3,
    ALU_OP_XOR   = 5'd4,
    ALU_OP_SLL   = 5'd5,
    ALU_OP_SRL   = 5'd6,
    ALU_OP_SRA   = 5'd7,
    ALU_OP_SLT   = 5'd8,
    ALU_OP_SLTU  = 5'd9,
    ALU_OP_LUI   = 5'd10,
    ALU_OP_AUIPC = 5'd11,
    ALU_OP_LB    = 5'd12,
    ALU_OP_LH    = 5'd13,
    ALU_OP_LW    = 5'd14,
    ALU_OP_LBU   = 5'd15,
    ALU_OP_LHU   = 5'd16,
    ALU_OP_SB    = 5'd17,
    ALU_OP_SH    = 5'd18,
    ALU_OP_SW    = 5'd19,
    ALU_OP_BEQ   = 5'd20,
    ALU_OP_BNE   = 5'd21,
    ALU_OP_BLT   = 5'd22,
    ALU_OP_BGE   = 5'd23,
    ALU_OP_BLTU  = 5'd24,
    ALU_OP_BGEU  = 5'd25,
    ALU_OP_JAL   = 5'd26,
    ALU_OP_JALR  = 5'd27
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_FLUSH = 2'd2
  } commit_state_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/commit_classify.sv
// Combinational opcode classifier: branch / jalr / store plus store access size.
// Shared with the ROB and LSB so all three agree on op classes.
module commit_classify
  import commit_unit_pkg::*;
(
  input  alu_op_e    op_i,
  output logic       is_branch_o,
  output logic       is_jalr_o,
  output logic       is_store_o,
  output logic [1:0] mem_size_o
);

  always_comb begin
    is_branch_o = 1'b0;
    is_jalr_o   = 1'b0;
    is_store_o  = 1'b0;
    mem_size_o  = MEM_SIZE_BYTE;
    case (op_i)
      ALU_OP_SB: begin is_store_o = 1'b1; mem_size_o = MEM_SIZE_BYTE; end
      ALU_OP_SH: begin is_store_o = 1'b1; mem_size_o = MEM_SIZE_HALF; end
      ALU_OP_SW: begin is_store_o = 1'b1; mem_size_o = MEM_SIZE_WORD; end
      ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT,
      ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU: is_branch_o = 1'b1;
      ALU_OP_JALR: is_jalr_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/commit_unit.sv
// Retire stage: acks the ROB head, writes the regfile, issues committed stores and
// raises flush/redirect on mispredicts. Optional counters under COMMIT_STATS_EN.
//
// state    | meaning
// ST_IDLE  | classify head; ack plain ops, launch store, or detect mispredict
// ST_STORE | store request held until mem_done (watchdog may flag store_err)
// ST_FLUSH | flush asserted for FLUSH_HOLD cycles, head left unacked
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int FLUSH_HOLD     = 1,
  parameter int MAX_STORE_WAIT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_valid,
  input  logic [ROB_ID_WIDTH-1:0] commit_id,
  input  alu_op_e                 commit_op,
  input  logic [4:0]              commit_rd,
  input  logic [31:0]             commit_value,
  input  logic [31:0]             commit_pc,
  input  logic [31:0]             commit_addr,
  input  logic                    commit_pred,
  input  logic                    commit_outcome,
  input  logic [31:0]             commit_pred_target,
  output logic                    commit_ack,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [ROB_ID_WIDTH-1:0] rf_rob_id,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [1:0]              mem_size,
  input  logic                    mem_done,
  output logic                    flush,
  output logic [31:0]             redirect_pc,
  output logic                    store_err
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]             cnt_retired,
  output logic [31:0]             cnt_flush
`endif
);

  localparam logic [1:0]  HOLD_INIT = 2'(FLUSH_HOLD - 1);
  localparam logic [15:0] WD_INIT   = 16'(MAX_STORE_WAIT - 1);

  commit_state_e state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic          flush_q, flush_d;
  logic [31:0]   redirect_q, redirect_d;
  logic          store_err_q, store_err_d;
  logic [1:0]    hold_q, hold_d;
  logic [15:0]   wd_q, wd_d;

  logic       is_branch, is_jalr, is_store;
  logic [1:0] cls_size;

  commit_classify u_classify (
    .op_i        (commit_op),
    .is_branch_o (is_branch),
    .is_jalr_o   (is_jalr),
    .is_store_o  (is_store),
    .mem_size_o  (cls_size)
  );

  logic        rd_nz, br_mispred, jalr_mispred;
  logic [31:0] pc_plus4;

  assign rd_nz        = (commit_rd != 5'd0);
  assign pc_plus4     = commit_pc + 32'd4;
  assign br_mispred   = (commit_pred != commit_outcome) ||
                        (commit_outcome && (commit_pred_target != commit_addr));
  assign jalr_mispred = (commit_pred_target != commit_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      store_err_q <= 1'b0;
      hold_q      <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      store_err_q <= store_err_d;
      hold_q      <= hold_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    flush_d     = flush_q;
    redirect_d  = redirect_q;
    store_err_d = store_err_q;
    hold_d      = hold_q;
    wd_d        = wd_q;
    commit_ack  = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_valid) begin
          if (is_store) begin
            mem_req_d   = 1'b1;
            mem_addr_d  = commit_addr;
            mem_wdata_d = commit_value;
            mem_size_d  = cls_size;
            wd_d        = WD_INIT;
            state_d     = ST_STORE;
          end else if (is_branch) begin
            if (br_mispred) begin
              flush_d    = 1'b1;
              redirect_d = commit_outcome ? commit_addr : pc_plus4;
              hold_d     = HOLD_INIT;
              state_d    = ST_FLUSH;
            end else begin
              commit_ack = 1'b1;
            end
          end else if (is_jalr) begin
            // Link register is written even when the target turns out wrong.
            rf_we = rd_nz;
            if (jalr_mispred) begin
              flush_d    = 1'b1;
              redirect_d = commit_addr;
              hold_d     = HOLD_INIT;
              state_d    = ST_FLUSH;
            end else begin
              commit_ack = 1'b1;
            end
          end else begin
            commit_ack = 1'b1;
            rf_we      = rd_nz;
          end
        end
      end
      ST_STORE: begin
        if (mem_done) begin
          commit_ack = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
        end else if (MAX_STORE_WAIT > 0) begin
          if (wd_q == 16'd0) store_err_d = 1'b1;
          else               wd_d        = wd_q - 16'd1;
        end
      end
      ST_FLUSH: begin
        if (hold_q == 2'd0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_waddr    = commit_rd;
  assign rf_wdata    = commit_value;
  assign rf_rob_id   = commit_id;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign store_err   = store_err_q;

`ifdef COMMIT_STATS_EN
  logic [31:0] cnt_retired_q, cnt_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_retired_q <= '0;
      cnt_flush_q   <= '0;
    end else begin
      if (commit_ack) cnt_retired_q <= cnt_retired_q + 32'd1;
      if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) cnt_flush_q <= cnt_flush_q + 32'd1;
    end
  end

  assign cnt_retired = cnt_retired_q;
  assign cnt_flush   = cnt_flush_q;
`endif

endmodule
